// File: rtl/uart_rx_sampler_if.sv
// Receiver-side signal bundle: oversample strobe and serial line in, byte and status pulses out.
// The master side feeds tick/rx; the receiver implements the slave side.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick;
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (output tick, rx, input data, valid, frame_err, busy);
    modport slave  (input tick, rx, output data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1-style UART receiver: mid-bit sampling driven by an external tick strobe,
// with start-glitch rejection, framing-error detection and a break-hold state.
module uart_rx_sampler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic               clk,
    input  logic               reset,
    uart_rx_sampler_if.slave   bus
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic [1:0]           sync_q;
    logic                 rx_s;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start after reset.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], bus.rx};
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Pulses default low every clk so they last one clk even when tick is slow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (bus.tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        cnt_d   = '0;
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        if (!rx_s) begin
                            cnt_d   = '0;
                            idx_d   = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) state_d = STOP;
                        else                   idx_d   = idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        if (rx_s) begin
                            data_d  = sh_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BRK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BRK: begin
                    // Hold here while the line stays low so a break is not decoded as frames.
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.data      = data_q;
        bus.valid     = valid_q;
        bus.frame_err = ferr_q;
        bus.busy      = (state_q != IDLE);
    end

endmodule
